// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the feature-map SRAM port arbiter.
package sram_arb_pkg;
  localparam int SRAM_ADDR_W = 12;
  localparam int SRAM_DATA_W = 8;

  localparam int RD_DISP = 0;
  localparam int RD_CONV = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_state_e;
endpackage

// File: rtl/sram_arb_rd_pipe.sv
// Read-return valid tags and data path for the SRAM arbiter.
// ARB_RDATA_REG_EN adds a data register and a second valid stage (latency 2).
module sram_arb_rd_pipe
  import sram_arb_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_rd_gnt,
  input  logic [DATA_W-1:0] i_sram_q,
  output logic [1:0]        o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_busy
);

  logic [1:0] vld1_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) vld1_q <= 2'b00;
    else       vld1_q <= i_rd_gnt;
  end

`ifdef ARB_RDATA_REG_EN
  logic [1:0]        vld2_q;
  logic [DATA_W-1:0] data_q;

  // Capture only real returns so the register never exposes stale SRAM output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld2_q <= 2'b00;
      data_q <= '0;
    end else begin
      vld2_q <= vld1_q;
      data_q <= (vld1_q != 2'b00) ? i_sram_q : '0;
    end
  end

  assign o_rd_valid = vld2_q;
  assign o_rd_data  = data_q;
  assign o_busy     = (vld1_q != 2'b00) | (vld2_q != 2'b00);
`else
  assign o_rd_valid = vld1_q;
  assign o_rd_data  = (vld1_q != 2'b00) ? i_sram_q : '0;
  assign o_busy     = (vld1_q != 2'b00);
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: write priority, burst-locked round-robin reads.
// Build option ARB_RDATA_REG_EN registers read data (see sram_arb_rd_pipe).
//
// state | meaning
// IDLE  | no burst owner; pick single requester or rr winner
// LOCK0 | display reader owns the read port until its last beat
// LOCK1 | conv reader owns the read port until its last beat
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_gnt,
  input  logic [1:0]        i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr0,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic [1:0]        i_rd_last,
  output logic [1:0]        o_rd_gnt,
  output logic [1:0]        o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_sram_cen,
  output logic              o_sram_wen,
  output logic [ADDR_W-1:0] o_sram_a,
  output logic [DATA_W-1:0] o_sram_d,
  input  logic [DATA_W-1:0] i_sram_q,
  output logic              o_busy
);

  lock_state_e state_q, state_d;
  logic        rr_q, rr_d;
  logic        sel;
  logic [1:0]  cand;
  logic [1:0]  rd_gnt;
  logic        wr_gnt;
  logic        pipe_busy;

  always_comb begin
    sel  = rr_q;
    cand = 2'b00;
    case (state_q)
      IDLE: begin
        case (i_rd_req)
          2'b01:   sel = 1'(RD_DISP);
          2'b10:   sel = 1'(RD_CONV);
          default: sel = rr_q;
        endcase
        if (i_rd_req != 2'b00) cand = sel ? 2'b10 : 2'b01;
      end
      LOCK0: begin
        sel  = 1'(RD_DISP);
        cand = {1'b0, i_rd_req[0]};
      end
      LOCK1: begin
        sel  = 1'(RD_CONV);
        cand = {i_rd_req[1], 1'b0};
      end
      default: begin
        sel  = rr_q;
        cand = 2'b00;
      end
    endcase
  end

  // A write steals the port for one cycle without touching the lock state.
  assign wr_gnt = i_wr_req & ~i_rst;
  assign rd_gnt = (i_rst | i_wr_req) ? 2'b00 : cand;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (rd_gnt != 2'b00) begin
          if (i_rd_last[sel]) rr_d = ~sel;
          else if (sel)       state_d = LOCK1;
          else                state_d = LOCK0;
        end
      end
      LOCK0, LOCK1: begin
        if (!i_rd_req[sel] || (rd_gnt[sel] && i_rd_last[sel])) begin
          state_d = IDLE;
          rr_d    = ~sel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    o_sram_cen = 1'b1;
    o_sram_wen = 1'b1;
    o_sram_a   = '0;
    o_sram_d   = '0;
    if (wr_gnt) begin
      o_sram_cen = 1'b0;
      o_sram_wen = 1'b0;
      o_sram_a   = i_wr_addr;
      o_sram_d   = i_wr_data;
    end else if (rd_gnt[RD_DISP]) begin
      o_sram_cen = 1'b0;
      o_sram_a   = i_rd_addr0;
    end else if (rd_gnt[RD_CONV]) begin
      o_sram_cen = 1'b0;
      o_sram_a   = i_rd_addr1;
    end
  end

  assign o_wr_gnt = wr_gnt;
  assign o_rd_gnt = rd_gnt;

  sram_arb_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rd_gnt   (rd_gnt),
    .i_sram_q   (i_sram_q),
    .o_rd_valid (o_rd_valid),
    .o_rd_data  (o_rd_data),
    .o_busy     (pipe_busy)
  );

  assign o_busy = (state_q != IDLE) | pipe_busy;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 4096x8 SRAM.
// Honours ARB_RDATA_REG_EN by expecting read returns two cycles after grant.
module tb_sram_port_arbiter;

`ifdef ARB_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_wr_req = 1'b0;
  logic [11:0] i_wr_addr = '0;
  logic [7:0]  i_wr_data = '0;
  logic        o_wr_gnt;
  logic [1:0]  i_rd_req = '0;
  logic [11:0] i_rd_addr0 = '0;
  logic [11:0] i_rd_addr1 = '0;
  logic [1:0]  i_rd_last = '0;
  logic [1:0]  o_rd_gnt;
  logic [1:0]  o_rd_valid;
  logic [7:0]  o_rd_data;
  logic        o_sram_cen;
  logic        o_sram_wen;
  logic [11:0] o_sram_a;
  logic [7:0]  o_sram_d;
  logic [7:0]  i_sram_q = '0;
  logic        o_busy;

  int npass = 0;
  int ntotal = 0;

  logic [7:0] mem [4096];
  logic [1:0] dl_v [2];
  logic [7:0] dl_d [2];

  always #5 i_clk = ~i_clk;

  sram_port_arbiter dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_req   (i_wr_req),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .o_wr_gnt   (o_wr_gnt),
    .i_rd_req   (i_rd_req),
    .i_rd_addr0 (i_rd_addr0),
    .i_rd_addr1 (i_rd_addr1),
    .i_rd_last  (i_rd_last),
    .o_rd_gnt   (o_rd_gnt),
    .o_rd_valid (o_rd_valid),
    .o_rd_data  (o_rd_data),
    .o_sram_cen (o_sram_cen),
    .o_sram_wen (o_sram_wen),
    .o_sram_a   (o_sram_a),
    .o_sram_d   (o_sram_d),
    .i_sram_q   (i_sram_q),
    .o_busy     (o_busy)
  );

  // Behavioural macro: q updates only on a read access.
  always @(posedge i_clk) begin
    if (!o_sram_cen) begin
      if (!o_sram_wen) mem[o_sram_a] <= o_sram_d;
      else             i_sram_q <= mem[o_sram_a];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) begin
      npass++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Checks one cycle at the falling edge; rdat is the data the granted read must return.
  task automatic step(input string tag, input logic wg, input logic [1:0] rg,
                      input logic [11:0] a, input logic [7:0] d,
                      input logic [7:0] rdat, input logic lock);
    logic [1:0] ev;
    logic [7:0] ed;
    logic       eb;
    @(negedge i_clk);
    ev = dl_v[LAT-1];
    ed = (ev != 2'b00) ? dl_d[LAT-1] : 8'h00;
    eb = lock | (dl_v[0] != 2'b00) | ((LAT == 2) && (dl_v[1] != 2'b00));
    chk({tag, ".wr_gnt"},   32'(o_wr_gnt),   32'(wg));
    chk({tag, ".rd_gnt"},   32'(o_rd_gnt),   32'(rg));
    chk({tag, ".cen"},      32'(o_sram_cen), 32'(!(wg || rg != 2'b00)));
    chk({tag, ".wen"},      32'(o_sram_wen), 32'(!wg));
    chk({tag, ".a"},        32'(o_sram_a),   32'(a));
    chk({tag, ".d"},        32'(o_sram_d),   32'(d));
    chk({tag, ".rd_valid"}, 32'(o_rd_valid), 32'(ev));
    chk({tag, ".rd_data"},  32'(o_rd_data),  32'(ed));
    chk({tag, ".busy"},     32'(o_busy),     32'(eb));
    dl_v[1] = dl_v[0];
    dl_d[1] = dl_d[0];
    dl_v[0] = rg;
    dl_d[0] = rdat;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    i_rst = 1'b1;
    i_wr_req = 1'b1;  i_wr_addr = 12'hABC;  i_wr_data = 8'h77;
    i_rd_req = 2'b11; i_rd_addr0 = 12'h001; i_rd_addr1 = 12'h002; i_rd_last = 2'b00;
    dl_v[0] = 2'b00; dl_v[1] = 2'b00; dl_d[0] = 8'h00; dl_d[1] = 8'h00;
    step(tag, 1'b0, 2'b00, 12'h000, 8'h00, 8'h00, 1'b0);
    i_rst = 1'b0;
    i_wr_req = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_rd_req = 2'b00; i_rd_addr0 = '0; i_rd_addr1 = '0; i_rd_last = 2'b00;
  endtask

  task automatic idle(input string tag);
    i_wr_req = 1'b0; i_rd_req = 2'b00; i_rd_last = 2'b00;
    step(tag, 1'b0, 2'b00, 12'h000, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
    dl_v[0] = 2'b00; dl_v[1] = 2'b00; dl_d[0] = 8'h00; dl_d[1] = 8'h00;

    do_reset("rst0");

    // Write wins over a simultaneous display read
    i_wr_req = 1'b1; i_wr_addr = 12'h123; i_wr_data = 8'hA5;
    i_rd_req = 2'b01; i_rd_addr0 = 12'h050; i_rd_last = 2'b01;
    step("wr", 1'b1, 2'b00, 12'h123, 8'hA5, 8'h00, 1'b0);
    i_wr_req = 1'b0; i_rd_addr0 = 12'h123;
    step("rdback", 1'b0, 2'b01, 12'h123, 8'h00, 8'hA5, 1'b0);
    idle("idle_a0");
    idle("idle_a1");

    // Display burst 000,001,008,009 with a write stealing cycle 2
    i_rd_req = 2'b01; i_rd_last = 2'b00; i_rd_addr0 = 12'h000;
    step("burst1", 1'b0, 2'b01, 12'h000, 8'h00, 8'h5A, 1'b0);
    i_rd_addr0 = 12'h001;
    i_wr_req = 1'b1; i_wr_addr = 12'h200; i_wr_data = 8'h3C;
    step("burst_pre", 1'b1, 2'b00, 12'h200, 8'h3C, 8'h00, 1'b1);
    i_wr_req = 1'b0;
    step("burst2", 1'b0, 2'b01, 12'h001, 8'h00, 8'h5B, 1'b1);
    i_rd_addr0 = 12'h008;
    step("burst3", 1'b0, 2'b01, 12'h008, 8'h00, 8'h52, 1'b1);
    i_rd_addr0 = 12'h009; i_rd_last = 2'b01;
    step("burst4", 1'b0, 2'b01, 12'h009, 8'h00, 8'h53, 1'b1);
    idle("idle_b0");
    idle("idle_b1");

    // Contention: 2-beat bursts alternate display/conv from reset; non-granted last bit ignored
    do_reset("rst1");
    i_rd_req = 2'b11; i_rd_addr0 = 12'h010; i_rd_addr1 = 12'h020;
    i_rd_last = 2'b10;
    step("cont1", 1'b0, 2'b01, 12'h010, 8'h00, 8'h4A, 1'b0);
    i_rd_last = 2'b11;
    step("cont2", 1'b0, 2'b01, 12'h010, 8'h00, 8'h4A, 1'b1);
    i_rd_last = 2'b01;
    step("cont3", 1'b0, 2'b10, 12'h020, 8'h00, 8'h7A, 1'b0);
    i_rd_last = 2'b11;
    step("cont4", 1'b0, 2'b10, 12'h020, 8'h00, 8'h7A, 1'b1);
    i_rd_last = 2'b00;
    step("cont5", 1'b0, 2'b01, 12'h010, 8'h00, 8'h4A, 1'b0);
    i_rd_last = 2'b01;
    step("cont6", 1'b0, 2'b01, 12'h010, 8'h00, 8'h4A, 1'b1);

    // Abort: conv locked then drops its request without last
    i_rd_req = 2'b10; i_rd_last = 2'b00;
    step("abort_g1", 1'b0, 2'b10, 12'h020, 8'h00, 8'h7A, 1'b0);
    step("abort_g2", 1'b0, 2'b10, 12'h020, 8'h00, 8'h7A, 1'b1);
    i_rd_req = 2'b01;
    step("abort", 1'b0, 2'b00, 12'h000, 8'h00, 8'h00, 1'b1);
    i_rd_req = 2'b11; i_rd_last = 2'b11;
    step("abort_next", 1'b0, 2'b01, 12'h010, 8'h00, 8'h4A, 1'b0);
    idle("idle_c0");
    idle("idle_c1");
    idle("idle_c2");

    // Reset the cycle after a read grant drops the in-flight return
    i_rd_req = 2'b01; i_rd_addr0 = 12'h009; i_rd_last = 2'b01;
    step("pre_rst", 1'b0, 2'b01, 12'h009, 8'h00, 8'h53, 1'b0);
    do_reset("rst_mid");
    idle("post_rst0");
    idle("post_rst1");
    idle("post_rst2");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
